execute_gr_writeback_scheduler: RTL and testbench
=================================================

Name: execute_gr_writeback_scheduler

Overview:
- Schedules general-register writebacks from two execute-stage producers onto the single GR writeback port. That port feeds the forwarding register and the register file.
- Producers: EX, the single-cycle ALU result path, and LS, the load-return path.
- Each producer has a small queue. Arbitration is load-priority with an EX starvation guard. The output stage is registered and honours a downstream stall.

Parameters:
- FIFO_DEPTH, 2, entries per producer queue; power of two, >=2.
- STARVE_LIMIT, 4, consecutive LS grants allowed while EX is non-empty before EX is forced; range 1..15.

Ports:
- iCLOCK  in  1  clock.
- iRESET_SYNC  in  1  synchronous active-high reset.
- iFLUSH  in  1  pipeline flush; drops all queued and output writebacks.
- iEX_REQ  in  1  EX writeback request.
- oEX_BUSY  out  1  EX queue full; the request is not accepted.
- iEX_DATA  in  32  EX result.
- iEX_DEST  in  5  EX destination register.
- iEX_DEST_SYSREG  in  1  EX destination is a system register.
- iLS_REQ  in  1  LS writeback request.
- oLS_BUSY  out  1  LS queue full.
- iLS_DATA  in  32  load data.
- iLS_DEST  in  5  LS destination register.
- iLS_DEST_SYSREG  in  1  LS destination is a system register.
- iWB_STALL  in  1  downstream cannot accept; hold the output.
- oWB_GR_VALID  out  1  writeback valid.
- oWB_GR_DATA  out  32  writeback data.
- oWB_GR_DEST  out  5  writeback destination.
- oWB_GR_DEST_SYSREG  out  1  system-register flag.
- iCHK_DEST  in  5  hazard-check destination (optional feature).
- iCHK_SYSREG  in  1  hazard-check system-register flag.
- oCHK_HIT  out  1  pending writeback matches the check destination.

Behaviour:
- Reset, with iRESET_SYNC high at a clock edge:
  - queues emptied, starvation counter cleared, arbiter state IDLE;
  - all oWB_* outputs 0; oEX_BUSY=0, oLS_BUSY=0, oCHK_HIT=0.
- iRESET_SYNC takes precedence over all other inputs.
- Enqueue:
  - an entry is accepted when xREQ=1 and xBUSY=0;
  - xBUSY = (count==FIFO_DEPTH) and is derived from the registered count;
  - a full queue refuses the request even if it dequeues in the same cycle;
  - a request made while busy is ignored; the producer must hold it.
- Output stage:
  - when iWB_STALL=0, the output register loads the granted queue head and that entry is dequeued;
  - if both queues are empty, oWB_GR_VALID is loaded with 0;
  - when iWB_STALL=1, all oWB_* hold their values and no dequeue occurs; enqueues continue.
- Latency: an accept at edge N with an empty queue and no stall gives oWB_GR_VALID=1 after edge N+1, i.e. 2 cycles. Each valid output is held for exactly one unstalled cycle.
- Arbiter FSM, evaluated only when iWB_STALL=0:
  - IDLE: both queues empty; no grant. Goes to LS_PRIO when either queue is non-empty.
  - LS_PRIO: grant LS if non-empty, else EX.
    - Each LS grant made while EX is non-empty increments the counter.
    - Goes to EX_FORCE when the counter reaches STARVE_LIMIT and EX is non-empty.
    - An EX grant clears the counter. EX empty clears the counter.
    - Goes to IDLE when both queues will be empty after this cycle's dequeue.
  - EX_FORCE: grant EX unconditionally, clear the counter, then go to LS_PRIO, or to IDLE if both queues are empty.
- Counter width is 4 bits and it saturates at STARVE_LIMIT.
- Ordering:
  - each queue is strictly FIFO;
  - there is no ordering across producers; decode guarantees no WAW pair in flight across EX and LS.
- iFLUSH:
  - same effect as reset on queues, counter, FSM and oWB_GR_VALID;
  - data outputs may keep their old values;
  - requests in the flush cycle are dropped;
  - flush overrides iWB_STALL.
- Simultaneous enqueue and dequeue on one queue: count unchanged; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: EXECUTE_WB_SCHED_HAZARD_CHECK_EN.
- Defined:
  - oCHK_HIT is combinational;
  - it is 1 if any valid entry in either queue, or a valid output register, has DEST==iCHK_DEST and DEST_SYSREG==iCHK_SYSREG;
  - decode uses it for interlock.
- Undefined: oCHK_HIT is tied to 0 and the comparators are not built; iCHK_* are unused.

Test Plan:
- Single EX request, DEST=3, DATA=0xDEADBEEF, no stall -> oWB_GR_VALID=1 for one cycle, 2 cycles after the accept, with DEST=3, DATA=0xDEADBEEF, SYSREG=0.
- EX and LS request in the same cycle, LS DEST=5 DATA=0x11, EX DEST=6 DATA=0x22 -> LS written back first, EX on the next cycle.
- LS streams continuously with EX holding one entry, STARVE_LIMIT=4 -> exactly 4 LS writebacks, then 1 EX writeback, then LS resumes.
- Fill EX queue with 2 entries while iWB_STALL=1 -> oEX_BUSY=1, a third request is ignored, outputs are held; release the stall -> both entries drain in order and oEX_BUSY drops.
- iFLUSH with 3 entries queued and oWB_GR_VALID=1 -> next cycle oWB_GR_VALID=0, both BUSY flags 0, no further writebacks; iRESET_SYNC mid-drain gives the same result.
- With EXECUTE_WB_SCHED_HAZARD_CHECK_EN defined, LS entry DEST=7 queued and iCHK_DEST=7, iCHK_SYSREG=0 -> oCHK_HIT=1; change to iCHK_SYSREG=1 -> 0; with the macro undefined -> always 0.

Source files
------------

// File: rtl/execute_gr_writeback_scheduler.sv
// GR writeback scheduler: EX and LS queues, load-priority arbiter with EX starvation guard.
// Define EXECUTE_WB_SCHED_HAZARD_CHECK_EN to build the pending-destination comparators.
module execute_gr_writeback_scheduler #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iEX_REQ,
  output logic        oEX_BUSY,
  input  logic [31:0] iEX_DATA,
  input  logic [4:0]  iEX_DEST,
  input  logic        iEX_DEST_SYSREG,
  input  logic        iLS_REQ,
  output logic        oLS_BUSY,
  input  logic [31:0] iLS_DATA,
  input  logic [4:0]  iLS_DEST,
  input  logic        iLS_DEST_SYSREG,
  input  logic        iWB_STALL,
  output logic        oWB_GR_VALID,
  output logic [31:0] oWB_GR_DATA,
  output logic [4:0]  oWB_GR_DEST,
  output logic        oWB_GR_DEST_SYSREG,
  input  logic [4:0]  iCHK_DEST,
  input  logic        iCHK_SYSREG,
  output logic        oCHK_HIT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 38;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LS_PRIO  = 2'd1;
  localparam logic [1:0] ST_EX_FORCE = 2'd2;

  // Index 0 is the EX queue, index 1 the LS queue; entry = {sysreg, dest, data}.
  logic [1:0]       req;
  logic [1:0]       busy;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;
  logic [1:0]       empty_next;
  logic [1:0]       grant;
  logic [1:0]       q_hit;
  logic [ENT_W-1:0] wr_entry [2];
  logic [ENT_W-1:0] head     [2];

  logic [1:0]       state_reg, state_next;
  logic [3:0]       starve_reg, starve_next;
  logic             out_valid_reg;
  logic [ENT_W-1:0] out_entry_reg;

  assign req         = {iLS_REQ, iEX_REQ};
  assign wr_entry[0] = {iEX_DEST_SYSREG, iEX_DEST, iEX_DATA};
  assign wr_entry[1] = {iLS_DEST_SYSREG, iLS_DEST, iLS_DATA};

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_queue
      logic [ENT_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [CNT_W-1:0] count_reg, count_next;

      assign busy[gi]       = (count_reg == CNT_W'(FIFO_DEPTH));
      assign push[gi]       = req[gi] && !busy[gi] && !iFLUSH && !iRESET_SYNC;
      assign pop[gi]        = grant[gi] && !iWB_STALL;
      assign nonempty[gi]   = (count_reg != '0);
      assign head[gi]       = mem[rd_ptr_reg];
      assign count_next     = count_reg + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
      assign empty_next[gi] = (count_next == '0);

      always_ff @(posedge iCLOCK) begin
        if (push[gi]) mem[wr_ptr_reg] <= wr_entry[gi];
      end

      always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC || iFLUSH) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_next;
        end
      end

`ifdef EXECUTE_WB_SCHED_HAZARD_CHECK_EN
      logic [FIFO_DEPTH-1:0] slot_hit;
      for (gj = 0; gj < FIFO_DEPTH; gj++) begin : g_slot
        logic [PTR_W-1:0] slot_ofs;
        assign slot_ofs     = PTR_W'(gj) - rd_ptr_reg;
        assign slot_hit[gj] = ({1'b0, slot_ofs} < count_reg) &&
                              (mem[gj][ENT_W-1:32] == {iCHK_SYSREG, iCHK_DEST});
      end
      assign q_hit[gi] = |slot_hit;
`else
      assign q_hit[gi] = 1'b0;
`endif
    end
  endgenerate

  // IDLE arbitrates like LS_PRIO so a freshly queued entry is granted on the next edge.
  always_comb begin
    grant       = 2'b00;
    state_next  = state_reg;
    starve_next = starve_reg;
    if (state_reg == ST_EX_FORCE) begin
      grant[0]    = nonempty[0];
      starve_next = 4'd0;
      state_next  = (&empty_next) ? ST_IDLE : ST_LS_PRIO;
    end else begin
      if (nonempty[1])      grant[1] = 1'b1;
      else if (nonempty[0]) grant[0] = 1'b1;
      if (!nonempty[0] || grant[0])
        starve_next = 4'd0;
      else if (grant[1] && starve_reg < 4'(STARVE_LIMIT))
        starve_next = starve_reg + 4'd1;
      if (&empty_next)
        state_next = ST_IDLE;
      else if (nonempty[0] && starve_next == 4'(STARVE_LIMIT))
        state_next = ST_EX_FORCE;
      else
        state_next = ST_LS_PRIO;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFLUSH) begin
      state_reg  <= ST_IDLE;
      starve_reg <= 4'd0;
    end else if (!iWB_STALL) begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  // On flush only the valid bit is cleared; stale data is harmless without it.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      out_valid_reg <= 1'b0;
      out_entry_reg <= '0;
    end else if (iFLUSH) begin
      out_valid_reg <= 1'b0;
    end else if (!iWB_STALL) begin
      out_valid_reg <= |grant;
      if (grant[1])      out_entry_reg <= head[1];
      else if (grant[0]) out_entry_reg <= head[0];
    end
  end

  assign oEX_BUSY           = busy[0];
  assign oLS_BUSY           = busy[1];
  assign oWB_GR_VALID       = out_valid_reg;
  assign oWB_GR_DATA        = out_entry_reg[31:0];
  assign oWB_GR_DEST        = out_entry_reg[36:32];
  assign oWB_GR_DEST_SYSREG = out_entry_reg[37];

`ifdef EXECUTE_WB_SCHED_HAZARD_CHECK_EN
  assign oCHK_HIT = (|q_hit) ||
                    (out_valid_reg && out_entry_reg[ENT_W-1:32] == {iCHK_SYSREG, iCHK_DEST});
`else
  logic unused_chk;
  assign unused_chk = ^{iCHK_DEST, iCHK_SYSREG, q_hit};
  assign oCHK_HIT   = 1'b0;
`endif

endmodule

// File: tb/tb_execute_gr_writeback_scheduler.sv
// Directed bench for execute_gr_writeback_scheduler: vector table plus flush/reset/hazard sequences.
module tb_execute_gr_writeback_scheduler;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC, iFLUSH, iWB_STALL;
  logic        iEX_REQ, iEX_DEST_SYSREG, iLS_REQ, iLS_DEST_SYSREG;
  logic [31:0] iEX_DATA, iLS_DATA;
  logic [4:0]  iEX_DEST, iLS_DEST, iCHK_DEST;
  logic        iCHK_SYSREG;
  logic        oEX_BUSY, oLS_BUSY, oWB_GR_VALID, oWB_GR_DEST_SYSREG, oCHK_HIT;
  logic [31:0] oWB_GR_DATA;
  logic [4:0]  oWB_GR_DEST;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iCLOCK = ~iCLOCK;

  execute_gr_writeback_scheduler #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH),
    .iEX_REQ(iEX_REQ), .oEX_BUSY(oEX_BUSY), .iEX_DATA(iEX_DATA),
    .iEX_DEST(iEX_DEST), .iEX_DEST_SYSREG(iEX_DEST_SYSREG),
    .iLS_REQ(iLS_REQ), .oLS_BUSY(oLS_BUSY), .iLS_DATA(iLS_DATA),
    .iLS_DEST(iLS_DEST), .iLS_DEST_SYSREG(iLS_DEST_SYSREG),
    .iWB_STALL(iWB_STALL), .oWB_GR_VALID(oWB_GR_VALID), .oWB_GR_DATA(oWB_GR_DATA),
    .oWB_GR_DEST(oWB_GR_DEST), .oWB_GR_DEST_SYSREG(oWB_GR_DEST_SYSREG),
    .iCHK_DEST(iCHK_DEST), .iCHK_SYSREG(iCHK_SYSREG), .oCHK_HIT(oCHK_HIT)
  );

  typedef struct {
    string       name;
    logic        ex_req;
    logic [4:0]  ex_dest;
    logic        ex_sys;
    logic [31:0] ex_data;
    logic        ls_req;
    logic [4:0]  ls_dest;
    logic [31:0] ls_data;
    logic        stall;
    logic        e_valid;
    logic [4:0]  e_dest;
    logic        e_sys;
    logic [31:0] e_data;
    logic        e_ex_busy;
    logic        e_ls_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name,
      input logic exr, input logic [4:0] exd, input logic exs, input logic [31:0] exdat,
      input logic lsr, input logic [4:0] lsd, input logic [31:0] lsdat, input logic stall,
      input logic ev, input logic [4:0] ed, input logic es, input logic [31:0] edat,
      input logic eexb, input logic elsb);
    vec_t v;
    v.name = name; v.ex_req = exr; v.ex_dest = exd; v.ex_sys = exs; v.ex_data = exdat;
    v.ls_req = lsr; v.ls_dest = lsd; v.ls_data = lsdat; v.stall = stall;
    v.e_valid = ev; v.e_dest = ed; v.e_sys = es; v.e_data = edat;
    v.e_ex_busy = eexb; v.e_ls_busy = elsb;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic exr, input logic [4:0] exd, input logic [31:0] exdat,
                        input logic lsr, input logic [4:0] lsd, input logic [31:0] lsdat,
                        input logic stall, input logic flush);
    iEX_REQ = exr; iEX_DEST = exd; iEX_DATA = exdat; iEX_DEST_SYSREG = 1'b0;
    iLS_REQ = lsr; iLS_DEST = lsd; iLS_DATA = lsdat; iLS_DEST_SYSREG = 1'b0;
    iWB_STALL = stall; iFLUSH = flush;
  endtask

  task automatic tick(input string tag);
    @(posedge iCLOCK); #1;
    $display("%s: valid=%0b dest=%0d sys=%0b data=%h ex_busy=%0b ls_busy=%0b",
             tag, oWB_GR_VALID, oWB_GR_DEST, oWB_GR_DEST_SYSREG, oWB_GR_DATA, oEX_BUSY, oLS_BUSY);
  endtask

  task automatic idle_check(input string tag, input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) begin
      tick(tag);
      check({tag, "_valid"}, 32'(oWB_GR_VALID), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic exp_hit;
`ifdef EXECUTE_WB_SCHED_HAZARD_CHECK_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    //          name       exr exd es exdat         lsr lsd lsdat  st | ev ed es edat         exb lsb
    vecs.push_back(mk("t1_acc",  1, 3, 0, 32'hDEADBEEF, 0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t1_out",  0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 3, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("t1_gap",  0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t2_acc",  1, 6, 0, 32'h22,       1, 5,  32'h11, 0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t2_ls",   0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 5, 0, 32'h11,       0, 0));
    vecs.push_back(mk("t2_ex",   0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 6, 0, 32'h22,       0, 0));
    vecs.push_back(mk("t2_gap",  0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t3_fill", 1, 9, 0, 32'h900,      1, 10, 32'hA0, 0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t3_ls0",  0, 0, 0, 32'h0,        1, 11, 32'hA1, 0,  1, 10, 0, 32'hA0,      0, 0));
    vecs.push_back(mk("t3_ls1",  0, 0, 0, 32'h0,        1, 12, 32'hA2, 0,  1, 11, 0, 32'hA1,      0, 0));
    vecs.push_back(mk("t3_ls2",  0, 0, 0, 32'h0,        1, 13, 32'hA3, 0,  1, 12, 0, 32'hA2,      0, 0));
    vecs.push_back(mk("t3_ls3",  0, 0, 0, 32'h0,        1, 14, 32'hA4, 0,  1, 13, 0, 32'hA3,      0, 0));
    vecs.push_back(mk("t3_ex",   0, 0, 0, 32'h0,        1, 15, 32'hA5, 0,  1, 9,  0, 32'h900,     0, 1));
    vecs.push_back(mk("t3_res0", 0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 14, 0, 32'hA4,      0, 0));
    vecs.push_back(mk("t3_res1", 0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 15, 0, 32'hA5,      0, 0));
    vecs.push_back(mk("t3_gap",  0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t4_a",    1, 1, 0, 32'h101,      0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));
    vecs.push_back(mk("t4_b",    1, 2, 1, 32'h102,      0, 0,  32'h0,  0,  1, 1, 0, 32'h101,      0, 0));
    vecs.push_back(mk("t4_stl",  1, 3, 0, 32'h103,      0, 0,  32'h0,  1,  1, 1, 0, 32'h101,      1, 0));
    vecs.push_back(mk("t4_ign",  1, 4, 0, 32'h104,      0, 0,  32'h0,  1,  1, 1, 0, 32'h101,      1, 0));
    vecs.push_back(mk("t4_d1",   0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 2, 1, 32'h102,      0, 0));
    vecs.push_back(mk("t4_d2",   0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  1, 3, 0, 32'h103,      0, 0));
    vecs.push_back(mk("t4_gap",  0, 0, 0, 32'h0,        0, 0,  32'h0,  0,  0, 0, 0, 32'h0,        0, 0));

    iCHK_DEST = 5'd31; iCHK_SYSREG = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    iRESET_SYNC = 1'b1;
    tick("reset");
    tick("reset");
    iRESET_SYNC = 1'b0;
    check("rst_valid",   32'(oWB_GR_VALID), 32'd0);
    check("rst_data",    oWB_GR_DATA, 32'd0);
    check("rst_dest",    32'(oWB_GR_DEST), 32'd0);
    check("rst_sys",     32'(oWB_GR_DEST_SYSREG), 32'd0);
    check("rst_ex_busy", 32'(oEX_BUSY), 32'd0);
    check("rst_ls_busy", 32'(oLS_BUSY), 32'd0);
    check("rst_chk",     32'(oCHK_HIT), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      set_in(v.ex_req, v.ex_dest, v.ex_data, v.ls_req, v.ls_dest, v.ls_data, v.stall, 1'b0);
      iEX_DEST_SYSREG = v.ex_sys;
      tick(v.name);
      check({v.name, "_valid"},   32'(oWB_GR_VALID), 32'(v.e_valid));
      check({v.name, "_ex_busy"}, 32'(oEX_BUSY), 32'(v.e_ex_busy));
      check({v.name, "_ls_busy"}, 32'(oLS_BUSY), 32'(v.e_ls_busy));
      if (v.e_valid) begin
        check({v.name, "_dest"}, 32'(oWB_GR_DEST), 32'(v.e_dest));
        check({v.name, "_sys"},  32'(oWB_GR_DEST_SYSREG), 32'(v.e_sys));
        check({v.name, "_data"}, oWB_GR_DATA, v.e_data);
      end
    end

    // Flush with three entries queued and a valid output, under stall and live requests.
    set_in(1, 20, 32'hF0, 1, 21, 32'hF1, 0, 0); tick("fl_a");
    check("fl_a_valid", 32'(oWB_GR_VALID), 32'd0);
    set_in(1, 22, 32'hF2, 0, 0, 0, 0, 0); tick("fl_b");
    check("fl_b_valid", 32'(oWB_GR_VALID), 32'd1);
    check("fl_b_dest",  32'(oWB_GR_DEST), 32'd21);
    set_in(0, 0, 0, 1, 23, 32'hF3, 1, 0); tick("fl_c");
    check("fl_c_valid",   32'(oWB_GR_VALID), 32'd1);
    check("fl_c_ex_busy", 32'(oEX_BUSY), 32'd1);
    set_in(1, 24, 32'hF4, 1, 24, 32'hF4, 1, 1); tick("fl_flush");
    check("fl_valid",   32'(oWB_GR_VALID), 32'd0);
    check("fl_ex_busy", 32'(oEX_BUSY), 32'd0);
    check("fl_ls_busy", 32'(oLS_BUSY), 32'd0);
    idle_check("fl_after", 4);

    // Reset in the middle of a drain.
    set_in(1, 25, 32'hE0, 0, 0, 0, 0, 0); tick("rs_a");
    set_in(1, 26, 32'hE1, 0, 0, 0, 0, 0); tick("rs_b");
    check("rs_b_dest", 32'(oWB_GR_DEST), 32'd25);
    set_in(0, 0, 0, 1, 27, 32'hE2, 0, 0); tick("rs_c");
    check("rs_c_valid", 32'(oWB_GR_VALID), 32'd1);
    check("rs_c_dest",  32'(oWB_GR_DEST), 32'd26);
    set_in(1, 28, 32'hE3, 1, 28, 32'hE3, 0, 0);
    iRESET_SYNC = 1'b1; tick("rs_reset"); iRESET_SYNC = 1'b0;
    check("rs_valid",   32'(oWB_GR_VALID), 32'd0);
    check("rs_data",    oWB_GR_DATA, 32'd0);
    check("rs_dest",    32'(oWB_GR_DEST), 32'd0);
    check("rs_ex_busy", 32'(oEX_BUSY), 32'd0);
    check("rs_ls_busy", 32'(oLS_BUSY), 32'd0);
    idle_check("rs_after", 3);

    // Hazard check against a queued LS entry, then against the output register.
    set_in(0, 0, 0, 1, 7, 32'h77, 1, 0); tick("hz_q");
    iCHK_DEST = 5'd7; iCHK_SYSREG = 1'b0; #1;
    check("hz_queue_hit", 32'(oCHK_HIT), 32'(exp_hit));
    iCHK_SYSREG = 1'b1; #1;
    check("hz_queue_sys_miss", 32'(oCHK_HIT), 32'd0);
    iCHK_SYSREG = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick("hz_out");
    check("hz_out_valid", 32'(oWB_GR_VALID), 32'd1);
    check("hz_out_dest",  32'(oWB_GR_DEST), 32'd7);
    check("hz_out_hit",   32'(oCHK_HIT), 32'(exp_hit));
    tick("hz_done");
    check("hz_done_valid", 32'(oWB_GR_VALID), 32'd0);
    check("hz_done_hit",   32'(oCHK_HIT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
